vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
//  Video input counterpart of the VGA output generator: accepts external 1-bpp video (hsync_n, vsync_n, pix)
//  and packs a window of pixels into video RAM bytes using the generator's layout (LSB = leftmost pixel,
//  LINE_BYTES per row, vertical line-doubling).
//  Sits on the video RAM write arbiter; CPU arms one-frame captures and polls busy/done/overflow.
// PARAMETERS
//  H_START     144  clocks from hsync_n falling edge to first captured pixel clock
//  H_PIX       320  captured pixels per row (multiple of 8)
//  PIX_DIV     2    clocks per pixel; sample taken on the first clock of each pixel
//  V_START     71   lines from vsync_n falling edge to first captured line
//  V_LINES     204  stored rows per frame
//  V_DIV       2    input lines per stored row (1 or 2); only the first line of each group is captured
//  LINE_BYTES  40   byte stride between stored rows
//  BASE_ADDR   0    video RAM address of row 0, byte 0
//  FIFO_DEPTH  4    write buffer entries (power of 2)
// PORTS
//  clk       in   1   main clock
//  rst_n     in   1   asynchronous reset, active low
//  arm       in   1   one-cycle pulse: start capture of the next full frame
//  hsync_n   in   1   input hsync, active low, asynchronous to clk
//  vsync_n   in   1   input vsync, active low, asynchronous to clk
//  pix       in   1   input pixel, asynchronous to clk
//  busy      out  1   high from accepted arm until done
//  done      out  1   capture finished and all bytes written; held until next arm
//  overflow  out  1   sticky: at least one byte dropped; cleared on accepted arm
//  wr_req    out  1   FIFO head valid
//  wr_addr   out  16  head byte address
//  wr_data   out  8   head byte data
//  wr_ack    in   1   arbiter accepted head this cycle
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0. Reset mid-frame aborts; no further writes.
//  Inputs: 2-FF synchronisers on hsync_n, vsync_n and pix (equal 2-clk delay). Edges detected on synced values.
//  FSM: IDLE -arm-> WAIT_VS -vsync_n fall-> FRAME -end-> DRAIN -FIFO empty-> DONE -arm-> WAIT_VS.
//   arm accepted in IDLE or DONE only; ignored while busy. Accepted arm clears done and overflow, sets busy.
//   WAIT_VS ignores everything except vsync_n falling edge.
//   FRAME end: last stored row's final byte pushed, or next vsync_n falling edge (short frame; partial
//    byte discarded). DRAIN->DONE: busy=0, done=1 same cycle FIFO becomes empty.
//  Counters (FRAME): hcnt 11b reset to 0 on hsync_n fall, +1 per clk, saturates at 2047.
//   vcnt 10b reset to 0 on vsync_n fall, +1 on each hsync_n fall, saturates at 1023.
//   Line active: vcnt in [V_START, V_START+V_LINES*V_DIV) and (vcnt-V_START)%V_DIV==0.
//   Pixel sample: line active, hcnt in [H_START, H_START+H_PIX*PIX_DIV), (hcnt-H_START)%PIX_DIV==0.
//  Packing: samples shift in at bit 7, shift right; 8th sample completes byte (first pixel in bit 0).
//   Completed byte pushed next clk with addr = BASE_ADDR + row*LINE_BYTES + col (16b, wraps mod 2^16),
//   row = (vcnt-V_START)/V_DIV, col = byte index in row (0..H_PIX/8-1).
//  FIFO: wr_req = !empty; wr_addr/wr_data = head, stable while wr_req && !wr_ack. Pop on wr_req && wr_ack.
//   wr_ack with wr_req low ignored. Push when full and no pop: byte dropped, overflow=1, address still advances.
//   Push and pop same cycle when full: both performed, no overflow.
//  hsync_n fall inside active window: current partial byte discarded, next line starts fresh.
// TESTING
//  Reset with pix=1 toggling syncs -> wr_req=0, busy=0, done=0, overflow=0, no writes ever.
//  arm, 640x480 generator timing, pix=1 always, wr_ack=1 -> 8160 writes, data 0xFF, addr 0..8159 ascending, then done=1.
//  pix alternating per PIX_DIV pixel (first pixel 1), line 71 -> byte@0 = 0x55, byte@39 = 0x55; line 72 writes nothing.
//  wr_ack tied 0 during first row -> first 4 bytes held (addr 0..3), overflow=1, first write after release addr 0, then addr 40.
//  vsync_n falling edge after row 10 -> last write addr 439, done=1 after drain; arm while busy ignored.
//  rst_n low mid-row 50 -> outputs 0 next cycle; arm after release -> capture restarts at addr 0 on next frame.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: samples external 1-bpp video (hsync_n/vsync_n/pix) and packs one window
// per armed frame into video RAM bytes, handed to the write arbiter through a small FIFO.
module vga_capture #(
  parameter int unsigned H_START    = 144,
  parameter int unsigned H_PIX      = 320,
  parameter int unsigned PIX_DIV    = 2,
  parameter int unsigned V_START    = 71,
  parameter int unsigned V_LINES    = 204,
  parameter int unsigned V_DIV      = 2,
  parameter int unsigned LINE_BYTES = 40,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arm,
  input  logic        hsync_n,
  input  logic        vsync_n,
  input  logic        pix,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        wr_req,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ack
);

  localparam int unsigned HCNT_W    = 11;
  localparam int unsigned VCNT_W    = 10;
  localparam int unsigned H_END     = H_START + H_PIX * PIX_DIV;
  localparam int unsigned V_END     = V_START + V_LINES * V_DIV;
  localparam int unsigned ROW_BYTES = H_PIX / 8;
  localparam int unsigned COL_W     = $clog2(ROW_BYTES) + 1;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VS,
    S_FRAME,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_arm_ok;

  logic r_hs_s1, r_hs_s2, r_hs_d;
  logic r_vs_s1, r_vs_s2, r_vs_d;
  logic r_px_s1, r_px_s2, r_px_d;
  logic w_hs_fall, w_vs_fall;

  logic [HCNT_W-1:0] r_hcnt;
  logic [VCNT_W-1:0] r_vcnt;
  logic [HCNT_W-1:0] w_hrel;
  logic [VCNT_W-1:0] w_vrel;
  logic [VCNT_W-1:0] w_row;
  logic              w_line_act, w_pix_act, w_sample, w_byte_done;
  logic [15:0]       w_addr;

  logic [6:0]       r_shreg;
  logic [2:0]       r_bitcnt;
  logic [COL_W-1:0] r_col;
  logic             r_push;
  logic             r_push_last;
  logic [7:0]       r_push_data;
  logic [15:0]      r_push_addr;

  logic [15:0]      r_fa [FIFO_DEPTH];
  logic [7:0]       r_fd [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_full, w_pop, w_wr, w_drop;

  logic r_busy, r_done, r_ovf, r_wr_req;

  // Input synchronisers; the extra stage on pix keeps it aligned with the edge-detect stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_s1 <= 1'b1;
      r_hs_s2 <= 1'b1;
      r_hs_d  <= 1'b1;
      r_vs_s1 <= 1'b1;
      r_vs_s2 <= 1'b1;
      r_vs_d  <= 1'b1;
      r_px_s1 <= 1'b0;
      r_px_s2 <= 1'b0;
      r_px_d  <= 1'b0;
    end else begin
      r_hs_s1 <= hsync_n;
      r_hs_s2 <= r_hs_s1;
      r_hs_d  <= r_hs_s2;
      r_vs_s1 <= vsync_n;
      r_vs_s2 <= r_vs_s1;
      r_vs_d  <= r_vs_s2;
      r_px_s1 <= pix;
      r_px_s2 <= r_px_s1;
      r_px_d  <= r_px_s2;
    end
  end

  assign w_hs_fall = r_hs_d & ~r_hs_s2;
  assign w_vs_fall = r_vs_d & ~r_vs_s2;

  // Raster position counters, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= '0;
      r_vcnt <= '0;
    end else begin
      if (w_hs_fall)
        r_hcnt <= '0;
      else if (r_hcnt != '1)
        r_hcnt <= r_hcnt + HCNT_W'(1);
      if (w_vs_fall)
        r_vcnt <= '0;
      else if (w_hs_fall && (r_vcnt != '1))
        r_vcnt <= r_vcnt + VCNT_W'(1);
    end
  end

  assign w_hrel     = r_hcnt - HCNT_W'(H_START);
  assign w_vrel     = r_vcnt - VCNT_W'(V_START);
  assign w_row      = w_vrel / VCNT_W'(V_DIV);
  assign w_line_act = (r_vcnt >= VCNT_W'(V_START)) && (r_vcnt < VCNT_W'(V_END)) &&
                      ((w_vrel % VCNT_W'(V_DIV)) == '0);
  assign w_pix_act  = (r_hcnt >= HCNT_W'(H_START)) && (r_hcnt < HCNT_W'(H_END)) &&
                      ((w_hrel % HCNT_W'(PIX_DIV)) == '0);
  assign w_sample   = (r_state == S_FRAME) && !w_hs_fall && !w_vs_fall && w_line_act && w_pix_act;
  assign w_byte_done = w_sample && (r_bitcnt == 3'd7);
  assign w_addr     = 16'(BASE_ADDR + (32'(w_row) * LINE_BYTES) + 32'(r_col));

  // Pixel packer: newest sample enters at the top so the leftmost pixel ends up in bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_col       <= '0;
      r_push      <= 1'b0;
      r_push_last <= 1'b0;
      r_push_data <= '0;
      r_push_addr <= '0;
    end else begin
      r_push <= w_byte_done;
      if (w_byte_done) begin
        r_push_data <= {r_px_d, r_shreg};
        r_push_addr <= w_addr;
        r_push_last <= (w_row == VCNT_W'(V_LINES - 1)) && (r_col == COL_W'(ROW_BYTES - 1));
      end
      if (w_hs_fall || w_vs_fall || (r_state != S_FRAME)) begin
        r_bitcnt <= '0;
        r_col    <= '0;
      end else if (w_sample) begin
        r_shreg  <= {r_px_d, r_shreg[6:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7)
          r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop  = r_wr_req && wr_ack;
  assign w_wr   = r_push && (!w_full || w_pop);
  assign w_drop = r_push && w_full && !w_pop;

  always_comb begin
    w_cnt_nxt = r_count;
    case ({w_wr, w_pop})
      2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
      2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  // Write buffer towards the video RAM arbiter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fa[i] <= '0;
        r_fd[i] <= '0;
      end
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_wr_req <= 1'b0;
    end else begin
      if (w_wr) begin
        r_fa[r_wptr] <= r_push_addr;
        r_fd[r_wptr] <= r_push_data;
        r_wptr       <= r_wptr + PTR_W'(1);
      end
      if (w_pop)
        r_rptr <= r_rptr + PTR_W'(1);
      r_count  <= w_cnt_nxt;
      r_wr_req <= (w_cnt_nxt != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm_ok    = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          w_state_nxt = S_WAIT_VS;
          w_arm_ok    = 1'b1;
        end
      end
      S_WAIT_VS: if (w_vs_fall) w_state_nxt = S_FRAME;
      S_FRAME:   if (w_vs_fall || (r_push && r_push_last)) w_state_nxt = S_DRAIN;
      S_DRAIN:   if (w_cnt_nxt == '0) w_state_nxt = S_DONE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags follow the next state so done rises on the edge the FIFO empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_WAIT_VS) || (w_state_nxt == S_FRAME) || (w_state_nxt == S_DRAIN);
      r_done <= (w_state_nxt == S_DONE);
      if (w_arm_ok)
        r_ovf <= 1'b0;
      else if (w_drop)
        r_ovf <= 1'b1;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;
  assign wr_req   = r_wr_req;
  assign wr_addr  = r_fa[r_rptr];
  assign wr_data  = r_fd[r_rptr];

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture: a raster generator drives the video inputs, directed
// frames push expected writes, and a negedge monitor compares every accepted write.
module tb_vga_capture;

  localparam int LINE_CLKS = 800;
  localparam int HS_LEN    = 96;
  localparam int VS_POS    = 400;
  localparam int WAIT_MAX  = 40000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        hsync_n = 1'b1;
  logic        vsync_n = 1'b1;
  logic        pix = 1'b1;
  logic        wr_ack = 1'b1;
  logic        busy, done, overflow, wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          g_frame = 0;
  int          g_line = 0;
  int          g_pos = 0;
  int          g_lines = 6;
  int          g_mode = 1;
  int          gen_f = 0;
  logic [15:0] last_addr = '0;

  always #5 clk = ~clk;

  vga_capture #(
    .V_START (3),
    .V_LINES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .arm      (arm),
    .hsync_n  (hsync_n),
    .vsync_n  (vsync_n),
    .pix      (pix),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack)
  );

  function automatic logic pix_val(input int p, input int m);
    if (m == 2) begin
      if (p < 144) return 1'b0;
      return ((((p - 144) / 2) % 2) == 0);
    end
    return 1'b1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic exp_range(input int a0, input int a1, input logic [7:0] d);
    exp_t e;
    for (int a = a0; a <= a1; a++) begin
      e.a = 16'(a);
      e.d = d;
      q.push_back(e);
    end
  endtask

  task automatic wait_at(input int f, input int l, input int p);
    int n;
    n = 0;
    while (!(g_frame == f && g_line == l && g_pos == p) && n < WAIT_MAX) begin
      @(posedge clk); #2;
      n++;
    end
    if (n >= WAIT_MAX) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_at f%0d l%0d p%0d: timed out, reached f%0d l%0d p%0d", f, l, p, g_frame, g_line, g_pos);
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (done !== 1'b1 && n < WAIT_MAX) begin
      @(posedge clk); #2;
      n++;
    end
    check(nm, 32'(done), 32'd1);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(posedge clk); #2;
    arm = 1'b0;
  endtask

  // Raster generator: 800 clocks per line, vsync falls mid line 0 and lasts two lines
  initial begin : gen
    forever begin
      int nl;
      nl = g_lines;
      for (int l = 0; l < nl; l++) begin
        for (int p = 0; p < LINE_CLKS; p++) begin
          @(posedge clk); #1;
          g_frame = gen_f;
          g_line  = l;
          g_pos   = p;
          hsync_n = (p >= HS_LEN);
          vsync_n = !((l == 0 && p >= VS_POS) || (l == 1) || (l == 2 && p < VS_POS));
          pix     = pix_val(p, g_mode);
        end
      end
      gen_f++;
    end
  end

  // Monitor: every accepted write must match the head of the expectation queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_req === 1'b1 && wr_ack === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", wr_addr, wr_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("write addr_data", {8'h00, wr_addr, wr_data}, {8'h00, e.a, e.d});
      end
      last_addr = wr_addr;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete, frame %0d line %0d", g_frame, g_line);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin : main
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("rst wr_req", 32'(wr_req), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Idle frame without arm: nothing may be written
    wait_at(0, 5, 0);
    check("idle busy", 32'(busy), 32'd0);
    check("idle done", 32'(done), 32'd0);
    check("idle wr_req", 32'(wr_req), 32'd0);
    g_lines = 12;

    // A: solid white frame
    exp_range(0, 159, 8'hFF);
    pulse_arm();
    repeat (3) @(posedge clk); #2;
    check("A busy", 32'(busy), 32'd1);
    wait_done("A done");
    check("A busy_clear", 32'(busy), 32'd0);
    check("A overflow", 32'(overflow), 32'd0);
    check("A queue_empty", 32'(q.size()), 32'd0);

    // B: alternating pixels, first pixel white
    wait_at(1, 11, 0);
    check("A done_held", 32'(done), 32'd1);
    g_mode = 2;
    exp_range(0, 159, 8'h55);
    pulse_arm();
    repeat (3) @(posedge clk); #2;
    check("B done_cleared", 32'(done), 32'd0);
    wait_done("B done");
    check("B queue_empty", 32'(q.size()), 32'd0);

    // C: arbiter stalls during the first row, buffer keeps the first four bytes
    wait_at(2, 11, 0);
    g_mode = 1;
    exp_range(0, 3, 8'hFF);
    exp_range(40, 159, 8'hFF);
    wr_ack = 1'b0;
    pulse_arm();
    wait_at(3, 4, 0);
    check("C hold wr_req", 32'(wr_req), 32'd1);
    check("C hold wr_addr", 32'(wr_addr), 32'd0);
    check("C hold wr_data", 32'(wr_data), 32'hFF);
    check("C overflow", 32'(overflow), 32'd1);
    wr_ack = 1'b1;
    wait_done("C done");
    check("C overflow_sticky", 32'(overflow), 32'd1);
    check("C queue_empty", 32'(q.size()), 32'd0);

    // D: short frame ends after two stored rows; arm while busy is ignored
    wait_at(3, 11, 0);
    g_lines = 6;
    exp_range(0, 79, 8'hFF);
    pulse_arm();
    repeat (3) @(posedge clk); #2;
    check("D overflow_cleared", 32'(overflow), 32'd0);
    wait_at(4, 1, 0);
    g_lines = 12;
    wait_at(4, 4, 0);
    pulse_arm();
    repeat (3) @(posedge clk); #2;
    check("D busy_after_arm", 32'(busy), 32'd1);
    check("D done_after_arm", 32'(done), 32'd0);
    wait_done("D done");
    check("D busy_clear", 32'(busy), 32'd0);
    check("D last_addr", 32'(last_addr), 32'd79);
    check("D queue_empty", 32'(q.size()), 32'd0);

    // E: reset in the middle of row 3, then a fresh capture
    wait_at(5, 11, 0);
    exp_range(0, 140, 8'hFF);
    pulse_arm();
    wait_at(6, 9, 490);
    rst_n = 1'b0;
    @(posedge clk); #2;
    check("E rst wr_req", 32'(wr_req), 32'd0);
    check("E rst busy", 32'(busy), 32'd0);
    check("E rst done", 32'(done), 32'd0);
    check("E rst wr_addr", 32'(wr_addr), 32'd0);
    check("E pre_reset_queue", 32'(q.size()), 32'd0);
    repeat (3) @(posedge clk); #2;
    rst_n = 1'b1;
    wait_at(6, 11, 0);
    check("E idle_after_reset", 32'(busy), 32'd0);
    exp_range(0, 159, 8'hFF);
    pulse_arm();
    wait_done("E done");
    check("E overflow", 32'(overflow), 32'd0);
    check("E queue_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
